// File: rtl/vga_bus_pkg.sv
// Shared definitions for the VGA peripheral bus: register offsets, frame
// limits, the fill-master state encoding and a small saturation helper.
package vga_bus_pkg;

    // Register offsets relative to the VGA peripheral base address.
    localparam logic [7:0] VGA_X_OFS   = 8'd0;
    localparam logic [7:0] VGA_Y_OFS   = 8'd1;
    localparam logic [7:0] VGA_PIX_OFS = 8'd2;

    // Last valid column / row of the 160x120 frame buffer.
    localparam int XMAX = 159;
    localparam int YMAX = 119;

    // Fill-master sequencing states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WR_Y = 3'd2,
        WR_X = 3'd3,
        WR_P = 3'd4,
        FIN  = 3'd5
    } fill_state_e;

    // Saturate an unsigned value to an upper limit (no wrap-around).
    function automatic logic [7:0] sat_u8(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Unsigned minimum / maximum of two bytes.
    function automatic logic [7:0] min_u8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? b : a;
    endfunction

endpackage

// File: rtl/rect_scan.sv
// Rectangle scanner: normalises and clamps the command corners when a fill
// is loaded, then walks (x,y) in row-major order under control of the FSM.
// The flags tell the FSM whether the current pixel ends a row or the fill.
module rect_scan
    import vga_bus_pkg::*;
#(
    parameter int X_LAST = XMAX,
    parameter int Y_LAST = YMAX
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] x0_i,
    input  logic [7:0] x1_i,
    input  logic [6:0] y0_i,
    input  logic [6:0] y1_i,
    input  logic       step_x_i,
    input  logic       step_row_i,
    output logic [7:0] x_o,
    output logic [6:0] y_o,
    output logic       last_in_row_o,
    output logic       last_pixel_o
);

    localparam logic [7:0] X_LIM = 8'(X_LAST);
    localparam logic [7:0] Y_LIM = {1'b0, 7'(Y_LAST)};

    // Normalised and saturated corners of the incoming command.
    logic [7:0] xl_n;
    logic [7:0] xh_n;
    logic [6:0] yl_n;
    logic [6:0] yh_n;

    // Bounds of the fill in progress and the current scan position.
    logic [7:0] xl_q, xl_d;
    logic [7:0] xh_q, xh_d;
    logic [6:0] yh_q, yh_d;
    logic [7:0] x_q,  x_d;
    logic [6:0] y_q,  y_d;

    // Order the corners low/high, then saturate both ends to the frame.
    always_comb begin
        xl_n = sat_u8(min_u8(x0_i, x1_i), X_LIM);
        xh_n = sat_u8(max_u8(x0_i, x1_i), X_LIM);
        yl_n = 7'(sat_u8(min_u8({1'b0, y0_i}, {1'b0, y1_i}), Y_LIM));
        yh_n = 7'(sat_u8(max_u8({1'b0, y0_i}, {1'b0, y1_i}), Y_LIM));
    end

    // Next scan position: load starts at the low corner, then step along
    // the row or wrap back to the left edge of the next row.
    always_comb begin
        xl_d = xl_q;
        xh_d = xh_q;
        yh_d = yh_q;
        x_d  = x_q;
        y_d  = y_q;
        if (load_i) begin
            xl_d = xl_n;
            xh_d = xh_n;
            yh_d = yh_n;
            x_d  = xl_n;
            y_d  = yl_n;
        end else if (step_row_i) begin
            x_d = xl_q;
            y_d = y_q + 7'd1;
        end else if (step_x_i) begin
            x_d = x_q + 8'd1;
        end
    end

    // Bound and position registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xl_q <= 8'd0;
            xh_q <= 8'd0;
            yh_q <= 7'd0;
            x_q  <= 8'd0;
            y_q  <= 7'd0;
        end else begin
            xl_q <= xl_d;
            xh_q <= xh_d;
            yh_q <= yh_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    // Counters never pass the clamped bounds, so ">=" is equality in practice
    // but stays safe if a bound were ever below the start.
    always_comb begin
        last_in_row_o = (x_q >= xh_q);
        last_pixel_o  = (x_q >= xh_q) && (y_q >= yh_q);
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/vga_rect_fill_master.sv
// Bus initiator filling rectangles in the VGA frame buffer. It requests the
// shared bus, then writes Y once per row and X plus pixel once per pixel.
// Any write state that sees the grant low falls back to REQ and restarts
// with a Y write so the pixel never lands on coordinates the processor may
// have changed in between.
module vga_rect_fill_master #(
    parameter logic [7:0] VGABaseAddress = 8'hB0,
    parameter int         XMAX           = vga_bus_pkg::XMAX,
    parameter int         YMAX           = vga_bus_pkg::YMAX
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [7:0] CMD_X0,
    input  logic [7:0] CMD_X1,
    input  logic [6:0] CMD_Y0,
    input  logic [6:0] CMD_Y1,
    input  logic       CMD_PIXEL,
    output logic       BUS_REQ,
    input  logic       BUS_GNT,
    output logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    output logic       BUS_WE,
    output logic       DONE
);

    import vga_bus_pkg::fill_state_e;
    import vga_bus_pkg::IDLE;
    import vga_bus_pkg::REQ;
    import vga_bus_pkg::WR_Y;
    import vga_bus_pkg::WR_X;
    import vga_bus_pkg::WR_P;
    import vga_bus_pkg::FIN;

    localparam logic [7:0] ADDR_X   = VGABaseAddress + vga_bus_pkg::VGA_X_OFS;
    localparam logic [7:0] ADDR_Y   = VGABaseAddress + vga_bus_pkg::VGA_Y_OFS;
    localparam logic [7:0] ADDR_PIX = VGABaseAddress + vga_bus_pkg::VGA_PIX_OFS;

    fill_state_e state_q, state_d;
    logic        pix_q, pix_d;

    logic        load;
    logic        step_x;
    logic        step_row;
    logic        in_wr;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    logic        last_in_row;
    logic        last_pixel;

    rect_scan #(
        .X_LAST (XMAX),
        .Y_LAST (YMAX)
    ) u_scan (
        .clk_i         (CLK),
        .rst_ni        (RESET),
        .load_i        (load),
        .x0_i          (CMD_X0),
        .x1_i          (CMD_X1),
        .y0_i          (CMD_Y0),
        .y1_i          (CMD_Y1),
        .step_x_i      (step_x),
        .step_row_i    (step_row),
        .x_o           (scan_x),
        .y_o           (scan_y),
        .last_in_row_o (last_in_row),
        .last_pixel_o  (last_pixel)
    );

    // State and captured pixel value; reset abandons any fill in progress.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            pix_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
        end
    end

    // Next-state logic, scanner control and the write to present this cycle.
    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        CMD_READY = 1'b0;
        BUS_REQ   = 1'b0;
        DONE      = 1'b0;
        in_wr     = 1'b0;
        wr_addr   = ADDR_X;
        wr_data   = 8'd0;
        load      = 1'b0;
        step_x    = 1'b0;
        step_row  = 1'b0;
        case (state_q)
            IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) begin
                    load    = 1'b1;
                    pix_d   = CMD_PIXEL;
                    state_d = REQ;
                end
            end
            REQ: begin
                BUS_REQ = 1'b1;
                if (BUS_GNT) begin
                    state_d = WR_Y;
                end
            end
            WR_Y: begin
                BUS_REQ = 1'b1;
                in_wr   = 1'b1;
                wr_addr = ADDR_Y;
                wr_data = {1'b0, scan_y};
                state_d = BUS_GNT ? WR_X : REQ;
            end
            WR_X: begin
                BUS_REQ = 1'b1;
                in_wr   = 1'b1;
                wr_addr = ADDR_X;
                wr_data = scan_x;
                state_d = BUS_GNT ? WR_P : REQ;
            end
            WR_P: begin
                BUS_REQ = 1'b1;
                in_wr   = 1'b1;
                wr_addr = ADDR_PIX;
                wr_data = {7'd0, pix_q};
                if (!BUS_GNT) begin
                    state_d = REQ;
                end else if (!last_in_row) begin
                    step_x  = 1'b1;
                    state_d = WR_X;
                end else if (!last_pixel) begin
                    step_row = 1'b1;
                    state_d  = WR_Y;
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus drive is gated by the live grant so nothing reaches the bus
    // in a cycle where another initiator owns it.
    assign BUS_WE   = in_wr & BUS_GNT;
    assign BUS_ADDR = BUS_WE ? wr_addr : 8'h00;
    assign BUS_DATA = BUS_WE ? wr_data : 8'hzz;

endmodule

// File: tb/tb_vga_rect_fill_master.sv
// Self-checking bench for vga_rect_fill_master: a table of fill commands
// with expected DONE cycle and pixel count, a scoreboard of expected bus
// writes, and hand-written grant-drop and reset sequences.
module tb_vga_rect_fill_master;

    localparam logic [7:0] BASE   = 8'hB0;
    localparam logic [7:0] A_X    = 8'hB0;
    localparam logic [7:0] A_Y    = 8'hB1;
    localparam logic [7:0] A_PIX  = 8'hB2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [7:0] CMD_X0, CMD_X1;
    logic [6:0] CMD_Y0, CMD_Y1;
    logic       CMD_PIXEL;
    logic       BUS_REQ;
    logic       BUS_GNT;
    logic [7:0] BUS_ADDR;
    wire  [7:0] BUS_DATA;
    logic       BUS_WE;
    logic       DONE;

    int checks   = 0;
    int failures = 0;
    int pix_cnt  = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    typedef struct {
        logic [7:0] x0;
        logic [7:0] x1;
        logic [6:0] y0;
        logic [6:0] y1;
        logic       pix;
        int         done_cyc;
        int         npix;
    } vec_t;
    vec_t vecs[7];

    vga_rect_fill_master #(
        .VGABaseAddress (BASE),
        .XMAX           (159),
        .YMAX           (119)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_X0    (CMD_X0),
        .CMD_X1    (CMD_X1),
        .CMD_Y0    (CMD_Y0),
        .CMD_Y1    (CMD_Y1),
        .CMD_PIXEL (CMD_PIXEL),
        .BUS_REQ   (BUS_REQ),
        .BUS_GNT   (BUS_GNT),
        .BUS_ADDR  (BUS_ADDR),
        .BUS_DATA  (BUS_DATA),
        .BUS_WE    (BUS_WE),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Reference model: normalise, saturate, then emit the row-major write list.
    task automatic push_rect(input int x0, input int x1, input int y0, input int y1, input logic pix);
        int xl, xh, yl, yh;
        xl = (x0 < x1) ? x0 : x1;
        xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;
        yh = (y0 < y1) ? y1 : y0;
        if (xl > 159) xl = 159;
        if (xh > 159) xh = 159;
        if (yl > 119) yl = 119;
        if (yh > 119) yh = 119;
        for (int y = yl; y <= yh; y++) begin
            push_wr(A_Y, 8'(y));
            for (int x = xl; x <= xh; x++) begin
                push_wr(A_X, 8'(x));
                push_wr(A_PIX, {7'd0, pix});
            end
        end
    endtask

    // Bus monitor: every granted write is popped from the scoreboard.
    always @(negedge CLK) begin
        if (RESET === 1'b1) begin
            if (BUS_WE === 1'b1) begin
                chk("we_needs_gnt", BUS_GNT, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0h data=%0h expected=none", BUS_ADDR, BUS_DATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("write addr=%0h data=%0h", BUS_ADDR, BUS_DATA);
                    chk("wr_addr", BUS_ADDR, mon_e.addr);
                    chk("wr_data", BUS_DATA, mon_e.data);
                    if (BUS_ADDR == A_PIX) pix_cnt++;
                end
            end else begin
                chk("idle_addr", BUS_ADDR, 0);
            end
        end
    end

    // Issue one command and follow it to DONE. Grant is low in cycles
    // [ds, ds+dl); a different command is offered in cycle bp while busy.
    task automatic run_cmd(input logic [7:0] x0, input logic [7:0] x1,
                           input logic [6:0] y0, input logic [6:0] y1, input logic pix,
                           input int ds, input int dl, input int bp, output int done_cyc);
        done_cyc = -1;
        @(posedge CLK);
        #1;
        CMD_X0 = x0; CMD_X1 = x1; CMD_Y0 = y0; CMD_Y1 = y1; CMD_PIXEL = pix;
        CMD_VALID = 1'b1;
        BUS_GNT = 1'b1;
        @(negedge CLK);
        chk("ready_before_accept", CMD_READY, 1);
        @(posedge CLK);
        for (int c = 1; c <= 400; c++) begin
            #1;
            CMD_VALID = (c == bp);
            if (c == bp) begin
                CMD_X0 = 8'd50; CMD_X1 = 8'd52; CMD_Y0 = 7'd50; CMD_Y1 = 7'd51; CMD_PIXEL = 1'b0;
            end
            BUS_GNT = !(dl > 0 && c >= ds && c < ds + dl);
            @(negedge CLK);
            if (c == 1) chk("req_cycle1", BUS_REQ, 1);
            if (!BUS_GNT) begin
                chk("drop_we", BUS_WE, 0);
                chk("drop_addr", BUS_ADDR, 0);
                chk("drop_req", BUS_REQ, 1);
            end
            if (DONE) begin
                done_cyc = c;
                break;
            end
            @(posedge CLK);
        end
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        BUS_GNT = 1'b1;
        @(negedge CLK);
        chk("ready_after_done", CMD_READY, 1);
        chk("done_one_cycle", DONE, 0);
        chk("req_after_done", BUS_REQ, 0);
    endtask

    int dc;

    initial begin
        vecs[0] = '{x0: 8'd5,   x1: 8'd5,   y0: 7'd7,   y1: 7'd7,   pix: 1'b1, done_cyc: 5,  npix: 1};
        vecs[1] = '{x0: 8'd10,  x1: 8'd11,  y0: 7'd20,  y1: 7'd21,  pix: 1'b1, done_cyc: 12, npix: 4};
        vecs[2] = '{x0: 8'd11,  x1: 8'd10,  y0: 7'd21,  y1: 7'd20,  pix: 1'b1, done_cyc: 12, npix: 4};
        vecs[3] = '{x0: 8'd158, x1: 8'd200, y0: 7'd118, y1: 7'd127, pix: 1'b1, done_cyc: 12, npix: 4};
        vecs[4] = '{x0: 8'd3,   x1: 8'd0,   y0: 7'd2,   y1: 7'd0,   pix: 1'b0, done_cyc: 29, npix: 12};
        vecs[5] = '{x0: 8'd159, x1: 8'd159, y0: 7'd119, y1: 7'd119, pix: 1'b0, done_cyc: 5,  npix: 1};
        vecs[6] = '{x0: 8'd255, x1: 8'd255, y0: 7'd127, y1: 7'd127, pix: 1'b1, done_cyc: 5,  npix: 1};

        RESET = 1'b0;
        CMD_VALID = 1'b0;
        CMD_X0 = 8'd0; CMD_X1 = 8'd0; CMD_Y0 = 7'd0; CMD_Y1 = 7'd0; CMD_PIXEL = 1'b0;
        BUS_GNT = 1'b1;
        #2;
        chk("rst_ready", CMD_READY, 1);
        chk("rst_req", BUS_REQ, 0);
        chk("rst_we", BUS_WE, 0);
        chk("rst_addr", BUS_ADDR, 0);
        chk("rst_done", DONE, 0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;

        // Table-driven fills with the grant held high.
        for (int i = 0; i < 7; i++) begin
            pix_cnt = 0;
            push_rect(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].pix);
            run_cmd(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].pix, 0, 0, 0, dc);
            $display("vec %0d rect (%0d,%0d)-(%0d,%0d) done_cycle=%0d pixels=%0d",
                     i, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, dc, pix_cnt);
            chk("done_cycle", dc, vecs[i].done_cyc);
            chk("pixel_count", pix_cnt, vecs[i].npix);
            chk("queue_empty", exp_q.size(), 0);
        end

        // Grant lost for cycles 5..7, right after the first pixel of a 3-wide row.
        pix_cnt = 0;
        push_wr(A_Y, 8'd5); push_wr(A_X, 8'd2); push_wr(A_PIX, 8'd1);
        push_wr(A_Y, 8'd5); push_wr(A_X, 8'd3); push_wr(A_PIX, 8'd1);
        push_wr(A_X, 8'd4); push_wr(A_PIX, 8'd1);
        run_cmd(8'd2, 8'd4, 7'd5, 7'd5, 1'b1, 5, 3, 0, dc);
        $display("grant drop fill done_cycle=%0d pixels=%0d", dc, pix_cnt);
        chk("drop_done_cycle", dc, 14);
        chk("drop_pixel_count", pix_cnt, 3);
        chk("drop_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a 10x10 fill.
        pix_cnt = 0;
        push_rect(0, 9, 0, 9, 1'b1);
        @(posedge CLK);
        #1;
        CMD_X0 = 8'd0; CMD_X1 = 8'd9; CMD_Y0 = 7'd0; CMD_Y1 = 7'd9; CMD_PIXEL = 1'b1;
        CMD_VALID = 1'b1;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        $display("reset mid-fill pixels_before_reset=%0d", pix_cnt);
        chk("midrst_ready", CMD_READY, 1);
        chk("midrst_req", BUS_REQ, 0);
        chk("midrst_we", BUS_WE, 0);
        chk("midrst_addr", BUS_ADDR, 0);
        chk("midrst_done", DONE, 0);
        chk("midrst_partial_pix", pix_cnt, 1);
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;

        // New fill after reset, with a second command offered while busy.
        pix_cnt = 0;
        push_rect(20, 21, 30, 30, 1'b1);
        run_cmd(8'd20, 8'd21, 7'd30, 7'd30, 1'b1, 0, 0, 3, dc);
        $display("post-reset fill done_cycle=%0d pixels=%0d", dc, pix_cnt);
        chk("post_done_cycle", dc, 7);
        chk("post_pixel_count", pix_cnt, 2);
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            chk("no_second_done", DONE, 0);
        end
        chk("post_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_rect_fill_master.md
# vga_rect_fill_master

Bus initiator that fills axis-aligned rectangles in the 160×120 one-bit frame buffer by issuing write sequences to the VGA peripheral's X (base+0), Y (base+1) and pixel (base+2) registers. It sits beside the processor on the shared 8-bit bus. It obtains the bus through a request/grant pair from the bus arbiter. It accepts one fill command at a time from a local command port.

## Interface
- `VGABaseAddress`, default 8'hB0: VGA peripheral base address.
- `XMAX`, default 159: last valid column.
- `YMAX`, default 119: last valid row.

Ports:
- `CLK` input 1: sole clock, rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `CMD_VALID` input 1: command offered.
- `CMD_READY` output 1: block idle, command can be accepted.
- `CMD_X0`, `CMD_X1` input 8 each: corner columns.
- `CMD_Y0`, `CMD_Y1` input 7 each: corner rows.
- `CMD_PIXEL` input 1: value written to every pixel.
- `BUS_REQ` output 1: bus requested.
- `BUS_GNT` input 1: bus granted by the arbiter, registered on the arbiter side.
- `BUS_ADDR` output 8: write address. 8'h00 when not writing.
- `BUS_DATA` inout 8: driven only while `BUS_WE`=1, otherwise high-Z.
- `BUS_WE` output 1: write strobe.
- `DONE` output 1: one-cycle pulse when a fill completes.

## Operation
- Reset values:
  - `CMD_READY`=1.
  - `BUS_REQ`=0, `BUS_WE`=0, `BUS_ADDR`=0, `BUS_DATA`=Z.
  - `DONE`=0.
  - State IDLE.
- Accept: a command is accepted on the rising edge where `CMD_VALID`&`CMD_READY`. Fields are captured in that cycle.
  - Normalise: xl=min(X0,X1), xh=max(X0,X1). Same for y.
  - Clamp: xh and xl to `XMAX`; yh and yl to `YMAX`. Clamping uses saturation, not wrap.
  - `CMD_VALID` while busy is ignored and not queued.
- States:
  - IDLE → REQ on accept.
  - REQ: `BUS_REQ`=1. Goes to WR_Y when `BUS_GNT`=1.
  - WR_Y: writes base+1 ← {1'b0,y}. Goes to WR_X.
  - WR_X: writes base+0 ← x. Goes to WR_P.
  - WR_P: writes base+2 ← {7'b0,`CMD_PIXEL`}. Then:
    - if x<xh: x++, go to WR_X.
    - else if y<yh: x=xl, y++, go to WR_Y.
    - else go to FIN.
  - FIN: `DONE`=1, `BUS_REQ`=0. Goes to IDLE.
- Scan order is row-major, starting at (xl,yl). Y is written once per row; X and pixel are written once per pixel. Raw Y is sent; the peripheral applies its own vertical flip.
- `BUS_REQ` stays high from REQ through the last WR_P.
- Write gating: in WR_* states, `BUS_WE`, `BUS_ADDR` and the `BUS_DATA` drive are active only while `BUS_GNT`=1, combinationally gated. The write counts when `BUS_GNT`=1 at the rising edge.
- Grant loss: `BUS_GNT`=0 in any WR_* state means no write that cycle and a move to REQ. After regaining the grant, resume at WR_Y then WR_X with the current (x,y). The processor may have rewritten X/Y meanwhile, so the pixel is never written against stale coordinates.
- Reset mid-fill: the fill is abandoned immediately and all outputs return to their reset values asynchronously. Partially drawn pixels remain.

## Timing
- Accept at edge 0. `BUS_REQ` rises in cycle 1 (REQ).
- With `BUS_GNT` held high: first write (Y) in cycle 2. A W×H rectangle takes H·(1+2W) write cycles. `DONE` fires in cycle 2+H·(1+2W). `CMD_READY` is 1 again in the following cycle.
- No wait states: one bus write per cycle.
- Each grant drop costs 1 REQ cycle plus 1 repeated Y write (2 total) plus the grant-low cycles.

## Structure
- Package `vga_bus_pkg`:
  - register offsets `VGA_X_OFS`=0, `VGA_Y_OFS`=1, `VGA_PIX_OFS`=2.
  - `XMAX` and `YMAX`.
  - the state enum.
  - These are shared with the VGA peripheral.
- Sub-module `rect_scan`: holds normalise/clamp logic and the x/y counters, with `last_in_row` and `last_pixel` flags. The top level contains only the FSM and bus drive.

## Test plan
- 1×1 fill (5,7), `PIXEL`=1, `GNT` tied high:
  - bus writes B1←07, B0←05, B2←01 in cycles 2–4.
  - `DONE` in cycle 5.
  - `CMD_READY`=1 in cycle 6.
- 2×2 fill, corners (10,20)/(11,21):
  - writes B1←14, B0←0A, B2, B0←0B, B2, B1←15, B0←0A, B2, B0←0B, B2.
  - `DONE` in cycle 12.
- Swapped corners (11,21)/(10,20): bus trace identical to the previous test.
- Clamp, X1=200, Y1=127, X0=158, Y0=118:
  - only columns 158–159 and rows 118–119 are written.
  - no address wraps.
- `GNT` dropped for 3 cycles after the first WR_P of a 3-wide row:
  - `BUS_WE`=0 and `BUS_DATA`=Z during the drop.
  - resumes with B1←y, B0←x+1, B2.
  - total pixel writes equal W·H.
- `RESET` asserted mid-fill:
  - outputs return to their reset values in the same cycle.
  - a new command after release completes normally.
  - `CMD_VALID` pulsed while busy is ignored (no second `DONE`).
